gin_bus_buffered: RTL and testbench

Second-generation global interconnect bus for the neural processor array. It broadcasts one source word per transfer to a parameterised set of target channels. Each channel holds a scan-programmed ID tag and a don't-care mask, so one transfer can multicast to any tag-matching subset of channels. Each channel buffers words in its own FIFO, so a stalled target does not block delivery to the other channels. It sits between the global buffer and a row or column of PE multicast ports, replacing the unbuffered single-tag bus.

---
 rtl/gin_bus_if.sv | 27 ++
 rtl/gin_bus_buffered.sv | 149 ++++++++++++++
 tb/tb_gin_bus_buffered.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gin_bus_if.sv
// Source-to-targets handshake and data bundle for the buffered global interconnect bus.
// Source side: bus_enable/bus_ready; target side: target_enable/target_ready per channel.
// A word moves on any rising edge where its valid and ready are both high.
interface gin_bus_if #(
  parameter int BITWIDTH        = 16,
  parameter int TAG_LENGTH      = 4,
  parameter int NUM_CONTROLLERS = 4
);
  logic                                bus_enable;
  logic                                bus_ready;
  logic [TAG_LENGTH-1:0]               tag;
  logic [BITWIDTH-1:0]                 data_source;
  logic [NUM_CONTROLLERS-1:0]          target_ready;
  logic [NUM_CONTROLLERS-1:0]          target_enable;
  logic [BITWIDTH*NUM_CONTROLLERS-1:0] output_value;
  logic                                bus_idle;

  modport master (
    output bus_enable, tag, data_source, target_ready,
    input  bus_ready, target_enable, output_value, bus_idle
  );

  modport slave (
    input  bus_enable, tag, data_source, target_ready,
    output bus_ready, target_enable, output_value, bus_idle
  );
endinterface

// File: rtl/gin_bus_buffered.sv
// Buffered multicast global interconnect bus: scan-programmed ID/mask per channel,
// one FIFO per target channel so a stalled target never blocks the others.
module gin_bus_buffered #(
  parameter int BITWIDTH        = 16,
  parameter int TAG_LENGTH      = 4,
  parameter int NUM_CONTROLLERS = 4,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rstb,
  // "program" is a reserved word in SystemVerilog, hence program_en
  input  logic                  program_en,
  input  logic [TAG_LENGTH-1:0] scan_tag_in,
  output logic [TAG_LENGTH-1:0] scan_tag_next_bus,
  gin_bus_if.slave              bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int NS = 2 * NUM_CONTROLLERS;

  // Stage 2i holds id[i], stage 2i+1 holds mask[i]
  logic [TAG_LENGTH-1:0] chain_q [NS];
  logic [TAG_LENGTH-1:0] chain_d [NS];

  logic [BITWIDTH-1:0] mem_q    [NUM_CONTROLLERS][FIFO_DEPTH];
  logic [BITWIDTH-1:0] mem_d    [NUM_CONTROLLERS][FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr_q [NUM_CONTROLLERS];
  logic [AW-1:0]       wr_ptr_d [NUM_CONTROLLERS];
  logic [AW-1:0]       rd_ptr_q [NUM_CONTROLLERS];
  logic [AW-1:0]       rd_ptr_d [NUM_CONTROLLERS];
  logic [CW-1:0]       count_q  [NUM_CONTROLLERS];
  logic [CW-1:0]       count_d  [NUM_CONTROLLERS];

  logic [NUM_CONTROLLERS-1:0]          match;
  logic [NUM_CONTROLLERS-1:0]          full;
  logic [NUM_CONTROLLERS-1:0]          empty;
  logic [NUM_CONTROLLERS-1:0]          push;
  logic [NUM_CONTROLLERS-1:0]          pop;
  logic                                ready_int;
  logic                                accept;
  logic [BITWIDTH*NUM_CONTROLLERS-1:0] out_vec;

  always_comb begin
    for (int k = 0; k < NS; k++) begin
      chain_d[k] = chain_q[k];
    end
    if (program_en) begin
      chain_d[0] = scan_tag_in;
      for (int k = 1; k < NS; k++) begin
        chain_d[k] = chain_q[k-1];
      end
    end
  end

  always_comb begin
    match = '0;
    full  = '0;
    empty = '0;
    for (int i = 0; i < NUM_CONTROLLERS; i++) begin
      match[i] = (((bus.tag ^ chain_q[2*i]) & ~chain_q[2*i+1]) == '0);
      full[i]  = (count_q[i] == CW'(FIFO_DEPTH));
      empty[i] = (count_q[i] == '0);
    end
  end

  // Ready looks only at FIFO occupancy, never at target_ready, so there is
  // no combinational path from the targets back to the source.
  always_comb begin
    ready_int = !program_en;
    for (int i = 0; i < NUM_CONTROLLERS; i++) begin
      if (match[i] && full[i]) begin
        ready_int = 1'b0;
      end
    end
  end

  assign accept = bus.bus_enable && ready_int;
  assign push   = match & {NUM_CONTROLLERS{accept}};
  assign pop    = ~empty & bus.target_ready;

  always_comb begin
    for (int i = 0; i < NUM_CONTROLLERS; i++) begin
      for (int j = 0; j < FIFO_DEPTH; j++) begin
        mem_d[i][j] = mem_q[i][j];
      end
      wr_ptr_d[i] = wr_ptr_q[i];
      rd_ptr_d[i] = rd_ptr_q[i];
      count_d[i]  = count_q[i];
      if (push[i]) begin
        mem_d[i][wr_ptr_q[i]] = bus.data_source;
        wr_ptr_d[i]           = wr_ptr_q[i] + AW'(1);
      end
      if (pop[i]) begin
        rd_ptr_d[i] = rd_ptr_q[i] + AW'(1);
      end
      case ({push[i], pop[i]})
        2'b10:   count_d[i] = count_q[i] + CW'(1);
        2'b01:   count_d[i] = count_q[i] - CW'(1);
        default: count_d[i] = count_q[i];
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      for (int k = 0; k < NS; k++) begin
        chain_q[k] <= '0;
      end
      for (int i = 0; i < NUM_CONTROLLERS; i++) begin
        for (int j = 0; j < FIFO_DEPTH; j++) begin
          mem_q[i][j] <= '0;
        end
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        count_q[i]  <= '0;
      end
    end else begin
      for (int k = 0; k < NS; k++) begin
        chain_q[k] <= chain_d[k];
      end
      for (int i = 0; i < NUM_CONTROLLERS; i++) begin
        for (int j = 0; j < FIFO_DEPTH; j++) begin
          mem_q[i][j] <= mem_d[i][j];
        end
        wr_ptr_q[i] <= wr_ptr_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
        count_q[i]  <= count_d[i];
      end
    end
  end

  // Empty channels present zero so stale FIFO contents never leak out
  always_comb begin
    out_vec = '0;
    for (int i = 0; i < NUM_CONTROLLERS; i++) begin
      if (!empty[i]) begin
        out_vec[BITWIDTH*i +: BITWIDTH] = mem_q[i][rd_ptr_q[i]];
      end
    end
  end

  assign bus.bus_ready      = ready_int;
  assign bus.target_enable  = ~empty;
  assign bus.output_value   = out_vec;
  assign bus.bus_idle       = &empty;
  assign scan_tag_next_bus  = chain_q[NS-1];

endmodule

// File: tb/tb_gin_bus_buffered.sv
// Self-checking bench for gin_bus_buffered: directed scenarios plus random traffic,
// checked every cycle against a queue-based reference model of the bus.
module tb_gin_bus_buffered;

  localparam int BW = 16;
  localparam int TL = 4;
  localparam int NC = 4;
  localparam int FD = 4;
  localparam int NS = 2 * NC;

  logic          clk;
  logic          rstb;
  logic          prog_en;
  logic [TL-1:0] scan_in;
  logic [TL-1:0] scan_out;

  gin_bus_if #(.BITWIDTH(BW), .TAG_LENGTH(TL), .NUM_CONTROLLERS(NC)) bus_if ();

  gin_bus_buffered #(
    .BITWIDTH(BW), .TAG_LENGTH(TL), .NUM_CONTROLLERS(NC), .FIFO_DEPTH(FD)
  ) dut (
    .clk               (clk),
    .rstb              (rstb),
    .program_en        (prog_en),
    .scan_tag_in       (scan_in),
    .scan_tag_next_bus (scan_out),
    .bus               (bus_if)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // reference model: per-channel word queues and the scan chain as a list of stages
  logic [BW-1:0] exp_q [NC][$];
  logic [TL-1:0] chain_m [$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic bit model_match(input int i, input logic [TL-1:0] t);
    logic [TL-1:0] diff;
    diff = (t ^ chain_m[2*i]) & ~chain_m[2*i+1];
    return diff == '0;
  endfunction

  function automatic bit model_ready(input logic [TL-1:0] t);
    bit r;
    r = !prog_en;
    for (int i = 0; i < NC; i++) begin
      if (model_match(i, t) && exp_q[i].size() >= FD) r = 1'b0;
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NC; i++) exp_q[i].delete();
    chain_m.delete();
    for (int k = 0; k < NS; k++) chain_m.push_back('0);
  endtask

  // One cycle: inputs were driven at the falling edge; check, then advance the model.
  task automatic tick(output bit acc);
    logic [NC*BW-1:0] exp_out;
    logic [NC-1:0]    exp_te, pops, pushes;
    logic [BW-1:0]    d;
    logic [TL-1:0]    sin;
    bit               rdy, p;
    #1;
    rdy     = model_ready(bus_if.tag);
    exp_te  = '0;
    exp_out = '0;
    for (int i = 0; i < NC; i++) begin
      if (exp_q[i].size() != 0) begin
        exp_te[i] = 1'b1;
        exp_out[i*BW +: BW] = exp_q[i][0];
      end
    end
    check("target_enable", bus_if.target_enable, exp_te);
    check("output_value",  bus_if.output_value,  exp_out);
    check("bus_ready",     bus_if.bus_ready,     rdy);
    check("bus_idle",      bus_if.bus_idle,      exp_te == '0);
    check("scan_out",      scan_out,             chain_m[NS-1]);
    acc    = bus_if.bus_enable && rdy;
    pops   = exp_te & bus_if.target_ready;
    pushes = '0;
    for (int i = 0; i < NC; i++) begin
      if (acc && model_match(i, bus_if.tag)) pushes[i] = 1'b1;
    end
    d   = bus_if.data_source;
    sin = scan_in;
    p   = prog_en;
    @(posedge clk);
    for (int i = 0; i < NC; i++) begin
      if (pops[i])   void'(exp_q[i].pop_front());
      if (pushes[i]) exp_q[i].push_back(d);
    end
    if (p) begin
      chain_m.push_front(sin);
      void'(chain_m.pop_back());
    end
    @(negedge clk);
  endtask

  task automatic idle_cycles(input int n);
    bit acc;
    for (int c = 0; c < n; c++) tick(acc);
  endtask

  // driver tasks
  task automatic send(input logic [TL-1:0] t, input logic [BW-1:0] d, input int budget);
    bit acc;
    int c;
    bus_if.bus_enable  = 1'b1;
    bus_if.tag         = t;
    bus_if.data_source = d;
    acc = 1'b0;
    c   = 0;
    while (!acc && c < budget) begin
      tick(acc);
      c++;
    end
    if (!acc) check("send_timeout", 0, 1);
    bus_if.bus_enable = 1'b0;
  endtask

  task automatic program_chain(input logic [NC-1:0][TL-1:0] ids,
                               input logic [NC-1:0][TL-1:0] masks);
    bit acc;
    prog_en = 1'b1;
    for (int k = NS - 1; k >= 0; k--) begin
      scan_in = (k % 2 == 1) ? masks[k/2] : ids[k/2];
      tick(acc);
    end
    prog_en = 1'b0;
    scan_in = '0;
  endtask

  logic [TL-1:0] scan_words [NS];
  logic [NC-1:0][TL-1:0] ids_seq, masks_zero, masks_one, rids, rmasks;

  initial begin
    bit acc;
    scan_words = '{4'h1, 4'h0, 4'h2, 4'h0, 4'h3, 4'h0, 4'h4, 4'h0};
    ids_seq    = {4'd3, 4'd2, 4'd1, 4'd0};
    masks_zero = '0;
    masks_one  = {4'h1, 4'h1, 4'h1, 4'h1};

    rstb                = 1'b0;
    prog_en             = 1'b0;
    scan_in             = '0;
    bus_if.bus_enable   = 1'b0;
    bus_if.tag          = '0;
    bus_if.data_source  = '0;
    bus_if.target_ready = '0;
    model_reset();

    // reset state
    #1;
    check("rst_target_enable", bus_if.target_enable, 0);
    check("rst_output_value",  bus_if.output_value,  0);
    check("rst_scan_out",      scan_out,             0);
    check("rst_bus_idle",      bus_if.bus_idle,      1);
    check("rst_bus_ready",     bus_if.bus_ready,     1);
    @(negedge clk);
    @(negedge clk);
    rstb = 1'b1;
    idle_cycles(2);

    // scan chain: shift 8 words, then 8 more and watch the originals emerge
    prog_en = 1'b1;
    for (int j = 0; j < NS; j++) begin
      scan_in = scan_words[j];
      tick(acc);
    end
    scan_in = '0;
    for (int j = 0; j < NS; j++) begin
      #1 check("scan_emerge", scan_out, scan_words[j]);
      tick(acc);
    end
    prog_en = 1'b0;

    // unicast
    program_chain(ids_seq, masks_zero);
    bus_if.target_ready = '1;
    send(4'h2, 16'hBEEF, 4);
    #1;
    check("uni_te",  bus_if.target_enable, 4'b0100);
    check("uni_out", bus_if.output_value,  {16'h0, 16'hBEEF, 32'h0});
    idle_cycles(2);

    // multicast by mask
    program_chain(ids_seq, masks_one);
    bus_if.target_ready = '0;
    send(4'h2, 16'h1234, 4);
    #1;
    check("mc_te",  bus_if.target_enable, 4'b1100);
    check("mc_out", bus_if.output_value,  {16'h1234, 16'h1234, 32'h0});
    bus_if.target_ready = '1;
    idle_cycles(2);
    bus_if.bus_enable  = 1'b1;
    bus_if.tag         = 4'hF;
    bus_if.data_source = 16'hDEAD;
    #1 check("mc_none_ready", bus_if.bus_ready, 1);
    tick(acc);
    bus_if.bus_enable = 1'b0;
    #1 check("mc_none_idle", bus_if.bus_idle, 1);
    check("mc_none_te", bus_if.target_enable, 0);
    idle_cycles(1);

    // back-pressure isolation
    program_chain(ids_seq, masks_zero);
    bus_if.target_ready = 4'b1101;
    for (int k = 0; k < 4; k++) send(4'h1, 16'hA000 + 16'(k), 4);
    bus_if.bus_enable  = 1'b1;
    bus_if.tag         = 4'h1;
    bus_if.data_source = 16'hA004;
    #1 check("bp_ready_low", bus_if.bus_ready, 0);
    idle_cycles(2);
    send(4'h0, 16'h5555, 4);
    idle_cycles(1);
    bus_if.target_ready = '1;
    send(4'h1, 16'hA004, 8);
    send(4'h1, 16'hA005, 8);
    idle_cycles(6);

    // simultaneous push/pop across pointer wrap
    bus_if.target_ready = '0;
    send(4'h2, 16'hC000, 4);
    send(4'h2, 16'hC001, 4);
    bus_if.target_ready = '1;
    bus_if.bus_enable   = 1'b1;
    bus_if.tag          = 4'h2;
    for (int k = 0; k < 12; k++) begin
      bus_if.data_source = 16'(k + 16'hC002);
      #1 check("pp_ready", bus_if.bus_ready, 1);
      tick(acc);
    end
    bus_if.bus_enable = 1'b0;
    idle_cycles(4);

    // program during drain
    bus_if.target_ready = '0;
    for (int k = 0; k < 3; k++) send(4'h0, 16'hD000 + 16'(k), 4);
    prog_en             = 1'b1;
    scan_in             = '0;
    bus_if.bus_enable   = 1'b1;
    bus_if.tag          = 4'h0;
    bus_if.target_ready = 4'b0001;
    #1 check("prog_ready_low", bus_if.bus_ready, 0);
    idle_cycles(4);
    #1 check("prog_drain_idle", bus_if.bus_idle, 1);
    prog_en           = 1'b0;
    bus_if.bus_enable = 1'b0;

    // random traffic
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < NC; i++) begin
        rids[i]   = TL'($urandom_range(0, 15));
        rmasks[i] = TL'($urandom_range(0, 15) & $urandom_range(0, 15));
      end
      program_chain(rids, rmasks);
      for (int c = 0; c < 80; c++) begin
        bus_if.bus_enable   = 1'($urandom_range(0, 1));
        bus_if.tag          = TL'($urandom_range(0, 15));
        bus_if.data_source  = BW'($urandom);
        bus_if.target_ready = NC'($urandom_range(0, 15));
        tick(acc);
      end
      bus_if.bus_enable   = 1'b0;
      bus_if.target_ready = '1;
      idle_cycles(FD + 1);
    end

    // asynchronous reset with words queued
    program_chain(ids_seq, masks_zero);
    bus_if.target_ready = '0;
    send(4'h3, 16'hF00D, 4);
    send(4'h3, 16'hF00E, 4);
    #2 rstb = 1'b0;
    #1;
    check("arst_te",    bus_if.target_enable, 0);
    check("arst_out",   bus_if.output_value,  0);
    check("arst_idle",  bus_if.bus_idle,      1);
    check("arst_ready", bus_if.bus_ready,     1);
    check("arst_scan",  scan_out,             0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rstb = 1'b1;
    bus_if.target_ready = '1;
    idle_cycles(2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
